// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined add/subtract unit built on a two-level carry-lookahead tree.
//   Per-bit generate/propagate feeds group generate/propagate (GROUP bits),
//   and a flattened lookahead across groups forms every group carry-in.
//   Only the bits inside one group ripple, so no chain exceeds GROUP bits.
//
//   Pipeline: STAGES=1 registers only the output, STAGES=2 adds a register
//   after the group P/G, STAGES=3 adds another after the group carries.
//   Each stage carries a valid bit; a stage loads when it is empty or the
//   stage after it is loading, so a stall holds all valid data in place.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   operands a/b/cin/sub are valid
//   in_ready   block accepts operands this cycle
//   a, b       operands, WIDTH bits
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0 = a+b+cin, 1 = a-b-cin
//   out_valid  sum/cout/ovf hold a result
//   out_ready  downstream accepts the result
//   sum        result, WIDTH bits
//   cout       carry-out of MSB (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
module cla_pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NG   = WIDTH / GROUP;
   localparam int DA_W = 2*WIDTH + 2*NG + 3;
   localparam int DB_W = 2*WIDTH + NG + 3;

   logic en_q;
   logic rdy_a, rdy_b, rdy_o;
   logic in_xfer;

   // front end: effective operand, bit P/G, group P/G
   logic [WIDTH-1:0] b_eff, p0, g0;
   logic [NG-1:0]    gg0, gp0;
   logic             c0;

   // subtract is a + ~b + ~cin, so cin behaves as an active-high borrow
   assign b_eff = b ^ {WIDTH{sub}};
   assign c0    = cin ^ sub;
   assign p0    = a ^ b_eff;
   assign g0    = a & b_eff;

   always_comb begin : grp_pg
      logic gacc, pacc;
      gacc = 1'b0;
      pacc = 1'b0;
      gg0  = '0;
      gp0  = '0;
      for (int k = 0; k < NG; k++) begin
         gacc = 1'b0;
         pacc = 1'b1;
         for (int i = 0; i < GROUP; i++) begin
            gacc = g0[k*GROUP+i] | (p0[k*GROUP+i] & gacc);
            pacc = pacc & p0[k*GROUP+i];
         end
         gg0[k] = gacc;
         gp0[k] = pacc;
      end
   end

   // stage A boundary: after group P/G
   logic [DA_W-1:0] da_in, da_out;
   logic            va_out;

   assign da_in = {p0, g0, gg0, gp0, c0, a[WIDTH-1], b_eff[WIDTH-1]};

   generate
      if (STAGES >= 2) begin : g_reg_a
         logic [DA_W-1:0] da_q;
         logic            va_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               va_q <= 1'b0;
               da_q <= '0;
            end else if (rdy_a) begin
               va_q <= in_xfer;
               if (in_xfer) da_q <= da_in;
            end
         end
         assign rdy_a  = ~va_q | rdy_b;
         assign da_out = da_q;
         assign va_out = va_q;
      end else begin : g_byp_a
         assign rdy_a  = rdy_b;
         assign da_out = da_in;
         assign va_out = in_xfer;
      end
   endgenerate

   logic [WIDTH-1:0] p1, g1;
   logic [NG-1:0]    gg1, gp1;
   logic             c01, am1, bm1;
   logic [NG:0]      gc;

   assign {p1, g1, gg1, gp1, c01, am1, bm1} = da_out;

   // Second-level lookahead, written as the full sum of products for each
   // group carry so no carry depends on the previous group's carry.
   // gc[NG] is the carry out of the MSB.
   always_comb begin : grp_carry
      logic t, acc;
      t   = 1'b0;
      acc = 1'b0;
      gc  = '0;
      for (int k = 0; k <= NG; k++) begin
         t = c01;
         for (int j = 0; j < k; j++) t = t & gp1[j];
         acc = t;
         for (int j = 0; j < k; j++) begin
            t = gg1[j];
            for (int m = j + 1; m < k; m++) t = t & gp1[m];
            acc = acc | t;
         end
         gc[k] = acc;
      end
   end

   // stage B boundary: after group carries
   logic [DB_W-1:0] db_in, db_out;
   logic            vb_out;

   assign db_in = {p1, g1, gc, am1, bm1};

   generate
      if (STAGES >= 3) begin : g_reg_b
         logic [DB_W-1:0] db_q;
         logic            vb_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vb_q <= 1'b0;
               db_q <= '0;
            end else if (rdy_b) begin
               vb_q <= va_out;
               if (va_out) db_q <= db_in;
            end
         end
         assign rdy_b  = ~vb_q | rdy_o;
         assign db_out = db_q;
         assign vb_out = vb_q;
      end else begin : g_byp_b
         assign rdy_b  = rdy_o;
         assign db_out = db_in;
         assign vb_out = va_out;
      end
   endgenerate

   logic [WIDTH-1:0] p2, g2, sum_d;
   logic [NG:0]      gc2;
   logic             am2, bm2, ovf_d;

   assign {p2, g2, gc2, am2, bm2} = db_out;

   // ripple confined to one group, seeded by that group's lookahead carry
   always_comb begin : grp_sum
      logic c;
      c     = 1'b0;
      sum_d = '0;
      for (int k = 0; k < NG; k++) begin
         c = gc2[k];
         for (int i = 0; i < GROUP; i++) begin
            sum_d[k*GROUP+i] = p2[k*GROUP+i] ^ c;
            c = g2[k*GROUP+i] | (p2[k*GROUP+i] & c);
         end
      end
   end

   assign ovf_d = (am2 == bm2) && (sum_d[WIDTH-1] != am2);

   // output stage
   logic             vo_q, cout_q, ovf_q;
   logic [WIDTH-1:0] sum_q;

   assign rdy_o = ~vo_q | out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vo_q   <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (rdy_o) begin
         vo_q <= vb_out;
         if (vb_out) begin
            sum_q  <= sum_d;
            cout_q <= gc2[NG];
            ovf_q  <= ovf_d;
         end
      end
   end

   // holds in_ready low through reset and until the first edge after it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) en_q <= 1'b0;
      else     en_q <= 1'b1;
   end

   assign in_ready  = en_q & rdy_a;
   assign in_xfer   = in_valid & in_ready;
   assign out_valid = vo_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, cout, ovf;
   logic [15:0] a = '0, b = '0, sum;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf));

   // eight small adders, one per (a msb, cin, sub) combination, so one
   // pass over a[6:0] x b[7:0] covers every a, b, cin and mode
   logic       xv = 1'b0;
   logic [6:0] xa = '0;
   logic [7:0] xb = '0;
   logic [7:0] x_rdy, x_ov, x_co, x_ovf;
   logic [7:0] x_sum [8];

   for (genvar i = 0; i < 8; i++) begin : g_x
      localparam logic KS = (i % 2) != 0;
      localparam logic KC = ((i / 2) % 2) != 0;
      localparam logic KA = ((i / 4) % 2) != 0;
      cla_pipe_adder #(.WIDTH(8), .GROUP(2), .STAGES(3)) u_x (
         .clk(clk), .rst(rst), .in_valid(xv), .in_ready(x_rdy[i]),
         .a({KA, xa}), .b(xb), .cin(KC), .sub(KS),
         .out_valid(x_ov[i]), .out_ready(1'b1),
         .sum(x_sum[i]), .cout(x_co[i]), .ovf(x_ovf[i]));
   end

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // returns {ovf, cout, sum[15:0]} from plain integer arithmetic
   function automatic logic [17:0] model(int w, longint ua, longint ub, logic c, logic s);
      longint ci, m, half, sa, sb, full, sv;
      logic co, ov;
      logic [63:0] t;
      ci   = c ? 1 : 0;
      m    = longint'(1) << w;
      half = m >> 1;
      sa   = (ua >= half) ? ua - m : ua;
      sb   = (ub >= half) ? ub - m : ub;
      if (s) begin
         full = ua - ub - ci;
         co   = (ua >= ub + ci);
         sv   = sa - sb - ci;
      end else begin
         full = ua + ub + ci;
         co   = (full >= m);
         sv   = sa + sb + ci;
      end
      ov = (sv >= half) || (sv < -half);
      t  = full & (m - 1);
      return {ov, co, t[15:0]};
   endfunction

   // ---------------- main scoreboard ----------------
   typedef struct {logic [17:0] e; int st;} ent_t;
   ent_t mq[$];
   int   n_in = 0, n_out = 0;
   bit   lat_chk = 1'b0;

   initial begin : main_cmp
      int          cyc;
      bit          pst;
      logic [17:0] pval;
      ent_t        e;
      cyc = 0; pst = 1'b0; pval = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            mq.delete();
            pst = 1'b0;
         end else begin
            if (pst) check("stall_hold", {out_valid, ovf, cout, sum}, {1'b1, pval});
            if (out_valid && out_ready) begin
               n_out++;
               if (mq.size() == 0) check("unexpected_result", out_valid, 0);
               else begin
                  e = mq.pop_front();
                  check("result", {ovf, cout, sum}, e.e);
                  if (lat_chk) check("latency", cyc - e.st, 2);
               end
            end
            if (in_valid && in_ready) begin
               n_in++;
               mq.push_back('{model(16, a, b, cin, sub), cyc});
            end
            pst  = out_valid && !out_ready;
            pval = {ovf, cout, sum};
         end
      end
   end

   // ---------------- sweep scoreboard ----------------
   typedef struct {logic [14:0] id; int st;} xent_t;
   xent_t xq[$];
   int    n_xout = 0;

   initial begin : sweep_cmp
      int          cyc;
      xent_t       e;
      logic [17:0] ex;
      longint      la;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) xq.delete();
         else begin
            if (x_rdy != 8'h00 && x_rdy != 8'hFF) check("x_rdy_sync", x_rdy, 8'hFF);
            if (x_ov != 8'h00) begin
               if (x_ov != 8'hFF) check("x_valid_sync", x_ov, 8'hFF);
               if (xq.size() == 0) check("x_unexpected", x_ov, 0);
               else begin
                  e = xq.pop_front();
                  n_xout++;
                  check("x_latency", cyc - e.st, 3);
                  for (int i = 0; i < 8; i++) begin
                     la = (longint'((i / 4) % 2) << 7) | longint'(e.id[14:8]);
                     ex = model(8, la, longint'(e.id[7:0]), ((i / 2) % 2) != 0, (i % 2) != 0);
                     check("x_res", {x_ovf[i], x_co[i], x_sum[i]}, {ex[17:16], ex[7:0]});
                  end
               end
            end
            if (xv && x_rdy[0]) xq.push_back('{{xa, xb}, cyc});
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [15:0] pick();
      logic [15:0] c [4];
      c[0] = 16'h0000; c[1] = 16'hFFFF; c[2] = 16'h7FFF; c[3] = 16'h8000;
      if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
      return 16'($urandom);
   endfunction

   task automatic rand_ops();
      a   = pick();
      b   = pick();
      cin = 1'($urandom);
      sub = 1'($urandom);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 50 && mq.size() > 0; k++) @(posedge clk);
      @(negedge clk);
      check("drain_empty", mq.size(), 0);
   endtask

   task automatic directed(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                           input logic ts, input logic [15:0] es, input logic ec,
                           input logic eo, input string nm);
      @(posedge clk); #1;
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({nm, "_early"}, out_valid, 0);
      @(posedge clk); #1;
      check({nm, "_valid"}, out_valid, 1);
      check({nm, "_sum"}, sum, es);
      check({nm, "_cout"}, cout, ec);
      check({nm, "_ovf"}, ovf, eo);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base, guard, idx, c;
      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 0);
      @(negedge clk); #2 rst = 1'b0;
      #1 check("ready_before_edge", in_ready, 0);
      @(posedge clk); #1 check("ready_after_edge", in_ready, 1);

      // directed values with exact latency
      lat_chk = 1'b1;
      directed(16'h00A0, 16'h0060, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add_basic");
      directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
      directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
      directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
      directed(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, "sub_borrow");
      directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
      directed(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "add_cin");
      drain();

      // back-to-back, one per cycle
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         rand_ops(); in_valid = 1'b1;
         check("b2b_ready", in_ready, 1);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      drain();
      lat_chk = 1'b0;

      // 8 operations, out_ready low for cycles 3..6
      base = n_out; idx = n_in; c = 0;
      while (n_in - idx < 8 && c < 40) begin
         c++;
         @(posedge clk); #1;
         out_ready = !(c >= 3 && c <= 6);
         rand_ops(); in_valid = 1'b1;
         @(negedge clk); #1;
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      drain();
      check("stall_count", n_out - base, 8);

      // random traffic with bubbles and stalls
      for (int k = 0; k < 800; k++) begin
         @(posedge clk); #1;
         rand_ops();
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      drain();
      check("rand_count", n_out, n_in);

      // reset with two operations in flight
      @(posedge clk); #1;
      out_ready = 1'b0; rand_ops(); in_valid = 1'b1;
      @(posedge clk); #1 rand_ops();
      @(posedge clk); #3;
      in_valid = 1'b0;
      base = n_out;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum", sum, 0);
      check("midrst_flags", {cout, ovf}, 0);
      check("midrst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); #2 rst = 1'b0;
      out_ready = 1'b1;
      #1 check("midrst_ready_before_edge", in_ready, 0);
      @(posedge clk); #1 check("midrst_ready_after_edge", in_ready, 1);
      repeat (8) @(posedge clk);
      @(negedge clk); #1;
      check("midrst_no_result", n_out - base, 0);

      // exhaustive sweep of the 8-bit, 3-stage configuration
      idx = 0; guard = 0;
      while (idx < 32768 && guard < 40000) begin
         @(posedge clk); #1;
         xa = idx[14:8]; xb = idx[7:0]; xv = 1'b1;
         @(negedge clk); #1;
         if (x_rdy[0]) idx++;
         guard++;
      end
      check("x_sweep_done", idx, 32768);
      @(posedge clk); #1 xv = 1'b0;
      for (int k = 0; k < 20 && xq.size() > 0; k++) @(posedge clk);
      @(negedge clk); #1;
      check("x_drain", xq.size(), 0);
      check("x_count", n_xout, 32768);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
